// File: rtl/frame_stream_ctrl_if.sv
// Bundle of the control, input-FIFO, core and result-FIFO signals of frame_stream_ctrl.
// The master modport is the controller side; the slave modport is the environment side.
interface frame_stream_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int RES_W  = 10,
    parameter int FRM_W  = 8,
    parameter int GAP_W  = 4
);
    logic              start;
    logic [FRM_W-1:0]  num_frames;
    logic [GAP_W-1:0]  gap_cycles;
    logic              reload;
    logic              load;
    logic              load_weight_done;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic              core_input_valid;
    logic              core_sof;
    logic [DATA_W-1:0] core_d_in;
    logic              core_output_valid;
    logic [RES_W-1:0]  core_d_out;
    logic              res_full;
    logic              res_wr_en;
    logic [RES_W-1:0]  res_data;
    logic              busy;
    logic              done;
    logic [FRM_W-1:0]  frame_idx;
    logic              err_overflow;

    modport master (
        input  start, num_frames, gap_cycles, reload, load_weight_done,
               fifo_empty, fifo_data, core_output_valid, core_d_out, res_full,
        output load, fifo_rd_en, core_input_valid, core_sof, core_d_in,
               res_wr_en, res_data, busy, done, frame_idx, err_overflow
    );

    modport slave (
        output start, num_frames, gap_cycles, reload, load_weight_done,
               fifo_empty, fifo_data, core_output_valid, core_d_out, res_full,
        input  load, fifo_rd_en, core_input_valid, core_sof, core_d_in,
               res_wr_en, res_data, busy, done, frame_idx, err_overflow
    );
endinterface

// File: rtl/frame_stream_ctrl.sv
// Multi-frame sequencer: optional weight load, N frames of FRAME_WORDS words with a read gap, result collection.
// Word reaches the core one cycle after its FIFO read; reads stall on fifo_empty, results are dropped (and flagged) on res_full.
module frame_stream_ctrl #(
    parameter int DATA_W        = 32,
    parameter int RES_W         = 10,
    parameter int FRAME_WORDS   = 784,
    parameter int RES_PER_FRAME = 1,
    parameter int FRM_W         = 8,
    parameter int GAP_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    frame_stream_ctrl_if.master bus
);
    localparam int WI_W = $clog2(FRAME_WORDS + 1);
    localparam int RC_W = $clog2(RES_PER_FRAME + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WLOAD, STREAM, DRAIN, WRES, FIN} state_t;

    state_t            state, state_nxt;
    logic [FRM_W-1:0]  nframes_q;
    logic [FRM_W-1:0]  frame_idx_q;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WI_W-1:0]   words_issued;
    logic [RC_W-1:0]   res_cnt;
    logic              wload_arm;
    logic              in_vld_q;
    logic              sof_q;
    logic              err_q;
    logic              start_ok;
    logic              rd_en;
    logic              last_read;
    logic              res_hit;
    logic              last_frame;
    logic              load_c;
    logic              done_c;
    logic              busy_c;

    assign start_ok   = bus.start && (bus.num_frames != '0);
    assign rd_en      = (state == STREAM) && !bus.fifo_empty && (gap_cnt == '0)
                        && (words_issued < WI_W'(FRAME_WORDS));
    assign last_read  = rd_en && (words_issued == WI_W'(FRAME_WORDS - 1));
    assign res_hit    = (state == WRES) && bus.core_output_valid
                        && (res_cnt == RC_W'(RES_PER_FRAME - 1));
    assign last_frame = (frame_idx_q == nframes_q - FRM_W'(1));

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        done_c    = 1'b0;
        busy_c    = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_ok)
                    state_nxt = (bus.reload || !bus.load_weight_done) ? LOAD : STREAM;
            end
            LOAD: begin
                load_c    = 1'b1;
                state_nxt = WLOAD;
            end
            // The core drops load_weight_done in response to load, so the first cycle is not trusted.
            WLOAD: begin
                if (wload_arm && bus.load_weight_done)
                    state_nxt = STREAM;
            end
            STREAM: begin
                if (last_read)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = WRES;
            WRES: begin
                if (res_hit)
                    state_nxt = last_frame ? FIN : STREAM;
            end
            FIN: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            nframes_q    <= '0;
            frame_idx_q  <= '0;
            gap_q        <= '0;
            gap_cnt      <= '0;
            words_issued <= '0;
            res_cnt      <= '0;
            wload_arm    <= 1'b0;
            in_vld_q     <= 1'b0;
            sof_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state     <= state_nxt;
            wload_arm <= (state == WLOAD);
            in_vld_q  <= rd_en;
            sof_q     <= rd_en && (words_issued == '0);
            if (bus.core_output_valid && bus.res_full)
                err_q <= 1'b1;
            if ((state == IDLE) && start_ok) begin
                nframes_q    <= bus.num_frames;
                gap_q        <= bus.gap_cycles;
                frame_idx_q  <= '0;
                words_issued <= '0;
                gap_cnt      <= '0;
                res_cnt      <= '0;
            end
            if (rd_en) begin
                words_issued <= words_issued + WI_W'(1);
                gap_cnt      <= gap_q;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            // Dropped results still count, so a full result FIFO cannot stall the run.
            if ((state == WRES) && bus.core_output_valid) begin
                if (res_hit) begin
                    res_cnt <= '0;
                    if (!last_frame) begin
                        frame_idx_q  <= frame_idx_q + FRM_W'(1);
                        words_issued <= '0;
                        gap_cnt      <= '0;
                    end
                end else begin
                    res_cnt <= res_cnt + RC_W'(1);
                end
            end
        end
    end

    assign bus.load             = load_c;
    assign bus.done             = done_c;
    assign bus.busy             = busy_c;
    assign bus.fifo_rd_en       = rd_en;
    assign bus.core_input_valid = in_vld_q;
    assign bus.core_sof         = sof_q;
    assign bus.core_d_in        = bus.fifo_data;
    assign bus.res_wr_en        = bus.core_output_valid && !bus.res_full;
    assign bus.res_data         = bus.core_output_valid ? bus.core_d_out : '0;
    assign bus.frame_idx        = frame_idx_q;
    assign bus.err_overflow     = err_q;
endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Bench for frame_stream_ctrl: behavioural FIFO/core/result models plus per-scenario checks.
module tb_frame_stream_ctrl;
    localparam int DATA_W = 32;
    localparam int RES_W  = 10;
    localparam int FW     = 784;
    localparam int FRM_W  = 8;
    localparam int GAP_W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_stream_ctrl_if #(.DATA_W(DATA_W), .RES_W(RES_W), .FRM_W(FRM_W), .GAP_W(GAP_W)) bus ();

    frame_stream_ctrl #(
        .DATA_W(DATA_W), .RES_W(RES_W), .FRAME_WORDS(FW), .RES_PER_FRAME(1),
        .FRM_W(FRM_W), .GAP_W(GAP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit               rand_empty = 0;
    bit               res_full_mode = 0;
    bit               force_res_val = 0;
    logic [RES_W-1:0] forced_val = '0;
    logic [RES_W-1:0] pend_res = '0;
    logic [RES_W-1:0] last_res = '0;
    int res_delay_ctr = -1;
    int lwd_ctr = -1;
    bit saw_load = 0;
    bit take;

    int cyc = 0;
    int valid_cnt, sof_cnt, sof_err, order_err, idx_err, load_cnt, done_cnt;
    int rd_cnt, res_wr_cnt, res_err, last_rd_cyc, min_rd_int, first_rd_cyc, start_cyc;

    task automatic clear_stats();
        valid_cnt = 0; sof_cnt = 0; sof_err = 0; order_err = 0; idx_err = 0;
        load_cnt = 0; done_cnt = 0; rd_cnt = 0; res_wr_cnt = 0; res_err = 0;
        last_rd_cyc = -1; min_rd_int = 1000000; first_rd_cyc = -1; start_cyc = -1;
    endtask

    // Environment: input FIFO, classifier core and result FIFO, observed at negedge, driven after posedge.
    initial begin
        bus.fifo_empty = 1'b1; bus.fifo_data = '0; bus.core_output_valid = 1'b0;
        bus.core_d_out = '0; bus.load_weight_done = 1'b0; bus.res_full = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            take = bus.fifo_rd_en;
            if (rst) begin
                res_delay_ctr = -1;
            end else begin
                if (bus.start && !bus.busy && bus.num_frames != '0) start_cyc = cyc;
                if (bus.load) begin load_cnt++; saw_load = 1; end
                if (bus.done) done_cnt++;
                if (bus.fifo_rd_en) begin
                    rd_cnt++;
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                    if (last_rd_cyc >= 0 && cyc - last_rd_cyc < min_rd_int) min_rd_int = cyc - last_rd_cyc;
                    last_rd_cyc = cyc;
                end
                if (bus.core_sof) begin
                    sof_cnt++;
                    if (!bus.core_input_valid || (valid_cnt % FW) != 0) sof_err++;
                    if (bus.frame_idx !== FRM_W'(valid_cnt / FW)) idx_err++;
                end else if (bus.core_input_valid && (valid_cnt % FW) == 0) begin
                    sof_err++;
                end
                if (bus.core_input_valid) begin
                    if (exp_q.size() == 0) order_err++;
                    else begin
                        if (bus.core_d_in !== exp_q[0]) order_err++;
                        void'(exp_q.pop_front());
                    end
                    valid_cnt++;
                    if ((valid_cnt % FW) == 0) begin
                        res_delay_ctr = $urandom_range(0, 3);
                        pend_res = force_res_val ? forced_val : RES_W'($urandom);
                    end
                end
                if (bus.res_wr_en) begin res_wr_cnt++; last_res = bus.res_data; end
                if (bus.core_output_valid && !bus.res_full) begin
                    if (!bus.res_wr_en || bus.res_data !== bus.core_d_out) res_err++;
                end else if (bus.res_wr_en) begin
                    res_err++;
                end
            end
            @(posedge clk);
            #1;
            if (take && src_q.size() > 0) bus.fifo_data = src_q.pop_front();
            bus.fifo_empty = (src_q.size() == 0) || (rand_empty && $urandom_range(0, 1) == 1);
            bus.res_full = res_full_mode;
            bus.core_output_valid = 1'b0;
            if (res_delay_ctr == 0) begin
                bus.core_output_valid = 1'b1;
                bus.core_d_out = pend_res;
                res_delay_ctr = -1;
            end else if (res_delay_ctr > 0) begin
                res_delay_ctr--;
            end
            if (saw_load) begin
                bus.load_weight_done = 1'b0;
                lwd_ctr = $urandom_range(1, 4);
                saw_load = 0;
            end else if (lwd_ctr == 0) begin
                bus.load_weight_done = 1'b1;
                lwd_ctr = -1;
            end else if (lwd_ctr > 0) begin
                lwd_ctr--;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic preload(input int n);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            src_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic do_start(input int nf, input int g, input bit rl);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.num_frames = FRM_W'(nf); bus.gap_cycles = GAP_W'(g); bus.reload = rl;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #3;
            if (done_cnt > 0) begin ok = 1; break; end
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.num_frames = '0; bus.gap_cycles = '0; bus.reload = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.load, bus.fifo_rd_en, bus.core_input_valid, bus.core_sof, bus.res_wr_en, bus.res_data,
                       bus.busy, bus.done, bus.err_overflow} !== '0)
            $display("FAIL reset_outputs: got %h want 0", {bus.load, bus.fifo_rd_en, bus.core_input_valid,
                     bus.core_sof, bus.res_wr_en, bus.res_data, bus.busy, bus.done, bus.err_overflow});
        else passed++;
        checks++; if (bus.frame_idx !== '0) $display("FAIL reset_frame_idx: got %0d want 0", bus.frame_idx); else passed++;
        @(posedge clk); #2; rst = 1'b0;
        clear_stats();
        do_start(0, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || load_cnt != 0)
            $display("FAIL zero_frames_ignored: busy %0b loads %0d want 0 0", bus.busy, load_cnt); else passed++;
    endtask

    task automatic test_single_frame();
        bit ok;
        clear_stats();
        force_res_val = 1; forced_val = RES_W'(9);
        preload(FW);
        do_start(1, 0, 1);
        wait_done(5000, ok);
        force_res_val = 0;
        checks++; if (!ok) $display("FAIL single_timeout: done not seen, want done"); else passed++;
        checks++; if (load_cnt != 1) $display("FAIL single_load: got %0d load cycles want 1", load_cnt); else passed++;
        checks++; if (valid_cnt != FW) $display("FAIL single_valids: got %0d want %0d", valid_cnt, FW); else passed++;
        checks++; if (sof_cnt != 1 || sof_err != 0) $display("FAIL single_sof: got %0d sof %0d misplaced want 1 0", sof_cnt, sof_err); else passed++;
        checks++; if (order_err != 0) $display("FAIL single_order: got %0d errors want 0", order_err); else passed++;
        checks++; if (res_wr_cnt != 1 || last_res !== RES_W'(9)) $display("FAIL single_result: got %0d writes data %0d want 1 9", res_wr_cnt, last_res); else passed++;
        checks++; if (res_err != 0) $display("FAIL single_res_path: got %0d errors want 0", res_err); else passed++;
        checks++; if (done_cnt != 1 || bus.busy !== 1'b0) $display("FAIL single_done: got %0d done busy %0b want 1 0", done_cnt, bus.busy); else passed++;
    endtask

    task automatic test_gap();
        bit ok;
        clear_stats();
        preload(3 * FW);
        do_start(3, 2, 0);
        repeat (50) @(posedge clk);
        do_start(5, 0, 1);
        wait_done(20000, ok);
        checks++; if (!ok) $display("FAIL gap_timeout: done not seen, want done"); else passed++;
        checks++; if (min_rd_int != 3) $display("FAIL gap_interval: got min %0d cycles want 3", min_rd_int); else passed++;
        checks++; if (rd_cnt != 3 * FW || valid_cnt != 3 * FW) $display("FAIL gap_counts: got rd %0d valid %0d want %0d", rd_cnt, valid_cnt, 3 * FW); else passed++;
        checks++; if (sof_cnt != 3 || sof_err != 0 || idx_err != 0) $display("FAIL gap_sof: got %0d sof %0d misplaced %0d idx want 3 0 0", sof_cnt, sof_err, idx_err); else passed++;
        checks++; if (bus.frame_idx !== FRM_W'(2)) $display("FAIL gap_frame_idx: got %0d want 2", bus.frame_idx); else passed++;
        checks++; if (done_cnt != 1 || load_cnt != 0) $display("FAIL gap_busy_start: got %0d done %0d loads want 1 0", done_cnt, load_cnt); else passed++;
    endtask

    task automatic test_random_empty();
        bit ok;
        clear_stats();
        rand_empty = 1;
        preload(2 * FW);
        do_start(2, 0, 1);
        wait_done(20000, ok);
        rand_empty = 0;
        checks++; if (!ok) $display("FAIL empty_timeout: done not seen, want done"); else passed++;
        checks++; if (valid_cnt != 2 * FW) $display("FAIL empty_valids: got %0d want %0d", valid_cnt, 2 * FW); else passed++;
        checks++; if (sof_cnt != 2 || sof_err != 0) $display("FAIL empty_sof: got %0d sof %0d misplaced want 2 0", sof_cnt, sof_err); else passed++;
        checks++; if (order_err != 0) $display("FAIL empty_order: got %0d errors want 0", order_err); else passed++;
        checks++; if (res_wr_cnt != 2 || res_err != 0 || done_cnt != 1) $display("FAIL empty_results: got %0d writes %0d errs %0d done want 2 0 1", res_wr_cnt, res_err, done_cnt); else passed++;
    endtask

    task automatic test_no_reload();
        bit ok;
        clear_stats();
        preload(FW);
        do_start(1, 0, 0);
        wait_done(5000, ok);
        checks++; if (!ok || done_cnt != 1) $display("FAIL noreload_done: got %0d done want 1", done_cnt); else passed++;
        checks++; if (load_cnt != 0) $display("FAIL noreload_load: got %0d load cycles want 0", load_cnt); else passed++;
        checks++; if (start_cyc < 0 || first_rd_cyc - start_cyc < 1 || first_rd_cyc - start_cyc > 2)
            $display("FAIL noreload_latency: got %0d cycles want 1..2", first_rd_cyc - start_cyc); else passed++;
    endtask

    task automatic test_overflow();
        bit ok;
        clear_stats();
        res_full_mode = 1;
        preload(FW);
        do_start(1, 0, 0);
        wait_done(5000, ok);
        checks++; if (!ok || done_cnt != 1) $display("FAIL ovf_done: got %0d done want 1", done_cnt); else passed++;
        checks++; if (res_wr_cnt != 0 || res_err != 0) $display("FAIL ovf_write: got %0d writes %0d errs want 0 0", res_wr_cnt, res_err); else passed++;
        res_full_mode = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.err_overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", bus.err_overflow); else passed++;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        ok = 0;
        clear_stats();
        preload(FW);
        do_start(1, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #3;
            if (valid_cnt >= 100) begin ok = 1; break; end
        end
        checks++; if (!ok) $display("FAIL midreset_reach: got %0d valids want 100", valid_cnt); else passed++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.load, bus.fifo_rd_en, bus.core_input_valid, bus.core_sof, bus.res_wr_en, bus.res_data,
                       bus.busy, bus.done, bus.frame_idx, bus.err_overflow} !== '0)
            $display("FAIL midreset_outputs: got %h want 0", {bus.load, bus.fifo_rd_en, bus.core_input_valid,
                     bus.core_sof, bus.res_wr_en, bus.res_data, bus.busy, bus.done, bus.frame_idx, bus.err_overflow});
        else passed++;
        @(posedge clk); #2;
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        clear_stats();
        preload(FW);
        do_start(1, 0, 1);
        wait_done(5000, ok);
        checks++; if (!ok || done_cnt != 1) $display("FAIL midreset_done: got %0d done want 1", done_cnt); else passed++;
        checks++; if (load_cnt != 1) $display("FAIL midreset_load: got %0d load cycles want 1", load_cnt); else passed++;
        checks++; if (sof_cnt != 1 || sof_err != 0 || order_err != 0 || valid_cnt != FW)
            $display("FAIL midreset_stream: got sof %0d misplaced %0d order %0d valids %0d want 1 0 0 %0d",
                     sof_cnt, sof_err, order_err, valid_cnt, FW);
        else passed++;
    endtask

    task automatic test_random_runs();
        bit ok;
        int nf, g;
        bit rl;
        for (int r = 0; r < 2; r++) begin
            nf = $urandom_range(1, 2);
            g  = $urandom_range(0, 3);
            rl = 1'($urandom_range(0, 1));
            rand_empty = 1'($urandom_range(0, 1));
            clear_stats();
            preload(nf * FW);
            do_start(nf, g, rl);
            wait_done(30000, ok);
            rand_empty = 0;
            checks++; if (!ok || done_cnt != 1) $display("FAIL rand%0d_done: got %0d done want 1", r, done_cnt); else passed++;
            checks++; if (valid_cnt != nf * FW || sof_cnt != nf || sof_err != 0 || idx_err != 0 || order_err != 0)
                $display("FAIL rand%0d_stream: got valids %0d sof %0d bad %0d/%0d/%0d want %0d %0d 0/0/0",
                         r, valid_cnt, sof_cnt, sof_err, idx_err, order_err, nf * FW, nf);
            else passed++;
            checks++; if (min_rd_int < g + 1) $display("FAIL rand%0d_gap: got min %0d want >= %0d", r, min_rd_int, g + 1); else passed++;
            checks++; if (res_wr_cnt != nf || res_err != 0) $display("FAIL rand%0d_results: got %0d writes %0d errs want %0d 0", r, res_wr_cnt, res_err, nf); else passed++;
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_frame();
        test_gap();
        test_random_empty();
        test_no_reload();
        test_overflow();
        test_reset_midframe();
        test_random_runs();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
